// File: rtl/key_req_pkg.sv
// Shared constants, FSM state type and priority helper for the key request latch.
package key_req_pkg;

  localparam int N_CH = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RECOVER = 2'd2
  } kr_state_e;

  // One-hot mask of the highest set bit; zero when nothing is set.
  function automatic logic [N_CH-1:0] hi_bit_mask(input logic [N_CH-1:0] v);
    logic [N_CH-1:0] m;
    m = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (v[i]) begin
        m    = '0;
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-channel 2-FF synchroniser and counter debouncer; pulses press on an
// accepted released->pressed transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_p1 != level);
  assign accept = differ && (cnt == CNT_LAST);
  // Combinational so the pending bit sets on the same edge the level flips.
  assign press  = accept && level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_req_latch.sv
// Debounced sticky key-request latch feeding an 8-to-3 priority encoder.
// Optional LOST_PRESS_EN adds oLost, flagging presses coalesced into a pending bit.
module key_req_latch
  import key_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [N_CH-1:0] iKey_n,
  input  logic            iAck,
  output logic [N_CH-1:0] oData,
  output logic            oEI,
  output logic            oValid
`ifdef LOST_PRESS_EN
  ,
  output logic            oLost
`endif
);

  logic [N_CH-1:0] press;
  logic [N_CH-1:0] pending;
  kr_state_e       state;
  logic            ack_acc;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (iClk),
      .rst_n(iRst_n),
      .key_n(iKey_n[i]),
      .press(press[i])
    );
  end

  assign ack_acc = (state == PRESENT) && iAck;
  assign oData   = pending;

  // A press landing on the bit being retired wins, so it stays pending.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pending <= '0;
      state   <= IDLE;
      oEI     <= 1'b1;
      oValid  <= 1'b0;
    end else begin
      if (ack_acc) begin
        pending <= (pending & ~hi_bit_mask(pending)) | press;
      end else begin
        pending <= pending | press;
      end
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state  <= PRESENT;
            oEI    <= 1'b0;
            oValid <= 1'b1;
          end
        end
        PRESENT: begin
          if (iAck) begin
            state  <= RECOVER;
            oEI    <= 1'b1;
            oValid <= 1'b0;
          end
        end
        RECOVER: begin
          if (pending != '0) begin
            state  <= PRESENT;
            oEI    <= 1'b0;
            oValid <= 1'b1;
          end else begin
            state  <= IDLE;
            oEI    <= 1'b1;
            oValid <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          oEI    <= 1'b1;
          oValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOST_PRESS_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oLost <= 1'b0;
    end else if ((press & pending) != '0) begin
      oLost <= 1'b1;
    end else if (ack_acc) begin
      oLost <= 1'b0;
    end
  end
`endif

endmodule
